// File: rtl/p1v_pin_pkg.sv
// Shared constants and types for the p1v pin input conditioning path.
// Imported by pin_input_sync and its per-pin filter slice.
package p1v_pin_pkg;

  localparam int P1V_NPINS = 32;

  localparam int P1V_SYNC_MIN = 2;
  localparam int P1V_SYNC_MAX = 4;

  localparam int P1V_FILTER_MIN = 1;
  localparam int P1V_FILTER_MAX = 8;

  typedef logic [P1V_NPINS-1:0] pin_vec_t;

endpackage

// File: rtl/pin_input_sync_filter_bit.sv
// One pin's conditioning slice: synchronizer chain, optional glitch filter,
// stable register and registered rise/fall edge detection.
module pin_filter_bit
  import p1v_pin_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_BITS = 3,
  parameter logic INIT        = 1'b0
) (
  input  logic clock_80,
  input  logic inp_resn,
  input  logic pin_in,
  input  logic filt_en,
  output logic sync_out,
  output logic edge_rise,
  output logic edge_fall
);

  localparam logic [FILTER_BITS-1:0] MAX = '1;

  // Pure flop chain so the placer can pack it tightly; nothing sits between stages.
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  logic [FILTER_BITS-1:0] r_cnt;
  logic [FILTER_BITS-1:0] w_cnt_next;
  logic                   r_stable;
  logic                   w_stable_next;
  logic                   w_s_last;
  logic                   r_rise;
  logic                   r_fall;

  assign w_s_last = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock_80 or negedge inp_resn) begin
    if (!inp_resn) begin
      r_sync <= {SYNC_STAGES{INIT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
    end
  end

  // A disabled filter follows the synchronizer directly and holds the count at zero,
  // so re-enabling always starts a fresh run and disabling mid-run commits at once.
  always_comb begin
    w_stable_next = r_stable;
    w_cnt_next    = '0;
    if (!filt_en) begin
      w_stable_next = w_s_last;
    end else if (w_s_last != r_stable) begin
      if (r_cnt == MAX) begin
        w_stable_next = w_s_last;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_80 or negedge inp_resn) begin
    if (!inp_resn) begin
      r_stable <= INIT;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_stable <= w_stable_next;
      r_cnt    <= w_cnt_next;
      r_rise   <= ~r_stable &  w_stable_next;
      r_fall   <=  r_stable & ~w_stable_next;
    end
  end

  assign sync_out  = r_stable;
  assign edge_rise = r_rise;
  assign edge_fall = r_fall;

endmodule

// File: rtl/pin_input_sync.sv
// Conditions the raw Propeller pad inputs for p1v.pin_in: per-pin sync/filter/edge
// slices plus the output-mirror bypass so driven pins read back with no delay.
module pin_input_sync
  import p1v_pin_pkg::*;
#(
  parameter int                NPINS       = P1V_NPINS,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILTER_BITS = 3,
  parameter logic [NPINS-1:0]  INIT        = {NPINS{1'b0}}
) (
  input  logic             clock_80,
  input  logic             inp_resn,
  input  logic [NPINS-1:0] pin_in,
  input  logic [NPINS-1:0] pin_out,
  input  logic [NPINS-1:0] pin_dir,
  input  logic [NPINS-1:0] filt_en,
  output logic [NPINS-1:0] sync_out,
  output logic [NPINS-1:0] prop_in,
  output logic [NPINS-1:0] edge_rise,
  output logic [NPINS-1:0] edge_fall
);

  if (SYNC_STAGES < P1V_SYNC_MIN || SYNC_STAGES > P1V_SYNC_MAX) begin : g_bad_sync
    $error("pin_input_sync: SYNC_STAGES must be within 2..4");
  end

  if (FILTER_BITS < P1V_FILTER_MIN || FILTER_BITS > P1V_FILTER_MAX) begin : g_bad_filter
    $error("pin_input_sync: FILTER_BITS must be within 1..8");
  end

  logic [NPINS-1:0] w_sync;

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    pin_filter_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_BITS (FILTER_BITS),
      .INIT        (INIT[i])
    ) u_pin (
      .clock_80  (clock_80),
      .inp_resn  (inp_resn),
      .pin_in    (pin_in[i]),
      .filt_en   (filt_en[i]),
      .sync_out  (w_sync[i]),
      .edge_rise (edge_rise[i]),
      .edge_fall (edge_fall[i])
    );
  end

  assign sync_out = w_sync;

  // Combinational on purpose: stays live through reset and reflects direction changes immediately.
  assign prop_in = (pin_dir & pin_out) | (~pin_dir & w_sync);

endmodule
